// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_wr_arbiter: round-robin, burst-limited sharing of one fifo write port  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int BURST_LEN  = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            in_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data_i,
  output logic [NUM_REQ-1:0]            in_ready_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
  input  logic                          fifo_wr_ready_i
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (BURST_LEN > 0) ? $clog2(BURST_LEN + 1) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e          state_q;
  logic [OW-1:0]   owner_q;
  logic [OW-1:0]   last_owner_q;
  logic [CW-1:0]   beat_cnt_q;

  logic [OW-1:0]         pick_d;
  logic                  hi_found;
  logic [OW-1:0]         hi_idx;
  logic [OW-1:0]         lo_idx;
  logic                  owner_valid;
  logic [DATA_WIDTH-1:0] owner_data;
  logic [NUM_REQ-1:0]    owner_onehot;
  logic                  active;
  logic                  xfer;

  // Requesters above last_owner take priority; otherwise wrap to the lowest one.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (in_valid_i[i]) begin
        if (OW'(i) > last_owner_q) begin
          hi_found = 1'b1;
          hi_idx   = OW'(i);
        end else begin
          lo_idx = OW'(i);
        end
      end
    end
    pick_d = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    owner_valid  = 1'b0;
    owner_data   = '0;
    owner_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OW'(i)) begin
        owner_valid     = in_valid_i[i];
        owner_data      = in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        owner_onehot[i] = 1'b1;
      end
    end
  end

  // Gated by reset so nothing is accepted at the reset edge.
  assign active         = (state_q == ST_BURST) && !reset_i;
  assign xfer           = active && owner_valid && fifo_wr_ready_i;
  assign busy_o         = (state_q == ST_BURST);
  assign grant_o        = busy_o ? owner_onehot : '0;
  assign fifo_wr_en_o   = active && owner_valid;
  assign fifo_wr_data_o = active ? owner_data : '0;
  assign in_ready_o     = xfer ? owner_onehot : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|in_valid_i) begin
            owner_q    <= pick_d;
            beat_cnt_q <= '0;
            state_q    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (xfer) begin
            if (beat_cnt_q == CW'(BURST_LEN - 1)) begin
              last_owner_q <= owner_q;
              state_q      <= ST_IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + CW'(1);
            end
          end else if (!owner_valid) begin
            last_owner_q <= owner_q;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// Directed bench for fifo_wr_arbiter with a small fifo write-side model.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_ready;
  logic [3:0]  grant;
  logic        busy;
  logic        fifo_wr_en;
  logic [3:0]  fifo_wr_data;
  logic        fifo_wr_ready;

  logic [4:0]  count;
  logic [4:0]  depth;
  logic        rd;
  logic        fifo_load;
  logic [4:0]  load_val;
  logic [3:0]  log_q [0:31];
  int          log_n;
  int          total;
  int          bad;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .BURST_LEN(2)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .in_valid_i     (in_valid),
    .in_data_i      (in_data),
    .in_ready_o     (in_ready),
    .grant_o        (grant),
    .busy_o         (busy),
    .fifo_wr_en_o   (fifo_wr_en),
    .fifo_wr_data_o (fifo_wr_data),
    .fifo_wr_ready_i(fifo_wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_wr_ready = (count < depth);

  always @(posedge clk) begin
    if (fifo_load) begin
      count <= load_val;
      log_n <= 0;
    end else begin
      count <= count + {4'd0, (fifo_wr_en && fifo_wr_ready)} - {4'd0, (rd && count != 5'd0)};
      if (fifo_wr_en && fifo_wr_ready) begin
        log_q[log_n] <= fifo_wr_data;
        log_n        <= log_n + 1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 4'b0; in_data = 16'h0; rd = 1'b0;
    depth = 5'd16; fifo_load = 1'b1; load_val = 5'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; fifo_load = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 4'b1111; in_data = 16'h3210; rd = 1'b0;
    depth = 5'd16; fifo_load = 1'b1; load_val = 5'd0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      total++;
      if ({grant, in_ready, fifo_wr_en, busy} !== 10'b0) begin
        bad++;
        $display("FAIL reset_outputs: got grant=%b ready=%b wr_en=%b busy=%b want all 0",
                 grant, in_ready, fifo_wr_en, busy);
      end
    end
    reset = 1'b0; fifo_load = 1'b0;
    @(negedge clk); #1;
    total++;
    if (grant !== 4'b0001) begin
      bad++; $display("FAIL reset_first_grant: got %b want 0001", grant);
    end
    in_valid = 4'b0;
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 4'b0010; in_data[7:4] = 4'd6;
    @(negedge clk); #1;
    total++;
    if (grant !== 4'b0010 || in_ready !== 4'b0010 || fifo_wr_data !== 4'd6) begin
      bad++; $display("FAIL single_beat1: got grant=%b ready=%b data=%0d want 0010 0010 6",
                      grant, in_ready, fifo_wr_data);
    end
    @(negedge clk); in_data[7:4] = 4'd8; #1;
    total++;
    if (grant !== 4'b0010 || fifo_wr_data !== 4'd8) begin
      bad++; $display("FAIL single_beat2: got grant=%b data=%0d want 0010 8", grant, fifo_wr_data);
    end
    @(negedge clk); in_data[7:4] = 4'd4; #1;
    total++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      bad++; $display("FAIL single_gap: got busy=%b grant=%b want 0 0000", busy, grant);
    end
    @(negedge clk); #1;
    total++;
    if (grant !== 4'b0010 || fifo_wr_data !== 4'd4) begin
      bad++; $display("FAIL single_regrant: got grant=%b data=%0d want 0010 4", grant, fifo_wr_data);
    end
    @(negedge clk); in_valid = 4'b0;
    @(negedge clk); #1;
    total++;
    if (busy !== 1'b0 || log_n !== 3 || log_q[0] !== 4'd6 || log_q[1] !== 4'd8 || log_q[2] !== 4'd4) begin
      bad++; $display("FAIL single_readback: got busy=%b n=%0d %0d,%0d,%0d want 0 3 6,8,4",
                      busy, log_n, log_q[0], log_q[1], log_q[2]);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_order [0:9];
    exp_order = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd0, 4'd0};
    do_reset();
    in_valid = 4'b1111; in_data = 16'h3210; rd = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk); #1;
      total++;
      if (busy !== ((k % 3) != 0)) begin
        bad++; $display("FAIL rr_busy_cycle%0d: got %b want %b", k, busy, ((k % 3) != 0));
      end
    end
    total++;
    if (log_n !== 10) begin
      bad++; $display("FAIL rr_count: got %0d want 10", log_n);
    end
    for (int j = 0; j < 10; j++) begin
      total++;
      if (log_q[j] !== exp_order[j]) begin
        bad++; $display("FAIL rr_order%0d: got %0d want %0d", j, log_q[j], exp_order[j]);
      end
    end
    in_valid = 4'b0; rd = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    fifo_load = 1'b1; load_val = 5'd3; depth = 5'd4;
    @(negedge clk);
    fifo_load = 1'b0; in_valid = 4'b0100; in_data[11:8] = 4'd10;
    @(negedge clk); #1;
    total++;
    if (grant !== 4'b0100 || in_ready !== 4'b0100 || fifo_wr_data !== 4'd10) begin
      bad++; $display("FAIL bp_first: got grant=%b ready=%b data=%0d want 0100 0100 10",
                      grant, in_ready, fifo_wr_data);
    end
    @(negedge clk); in_data[11:8] = 4'd12;
    for (int h = 0; h < 2; h++) begin
      #1;
      total++;
      if (in_ready !== 4'b0000 || grant !== 4'b0100 || fifo_wr_en !== 1'b1 || dut.beat_cnt_q !== 2'd1) begin
        bad++; $display("FAIL bp_hold%0d: got ready=%b grant=%b wr_en=%b cnt=%0d want 0000 0100 1 1",
                        h, in_ready, grant, fifo_wr_en, dut.beat_cnt_q);
      end
      @(negedge clk);
    end
    rd = 1'b1;
    @(negedge clk); rd = 1'b0; #1;
    total++;
    if (in_ready !== 4'b0100 || fifo_wr_data !== 4'd12) begin
      bad++; $display("FAIL bp_resume: got ready=%b data=%0d want 0100 12", in_ready, fifo_wr_data);
    end
    @(negedge clk); in_valid = 4'b0; #1;
    total++;
    if (busy !== 1'b0 || log_n !== 2 || log_q[0] !== 4'd10 || log_q[1] !== 4'd12) begin
      bad++; $display("FAIL bp_end: got busy=%b n=%0d %0d,%0d want 0 2 10,12",
                      busy, log_n, log_q[0], log_q[1]);
    end
  endtask

  task automatic test_early_release();
    do_reset();
    in_valid = 4'b1001; in_data = 16'h7005;
    @(negedge clk); #1;
    total++;
    if (grant !== 4'b0001 || fifo_wr_data !== 4'd5) begin
      bad++; $display("FAIL er_grant0: got grant=%b data=%0d want 0001 5", grant, fifo_wr_data);
    end
    @(negedge clk); in_valid = 4'b1000; #1;
    total++;
    if (in_ready !== 4'b0000 || fifo_wr_en !== 1'b0) begin
      bad++; $display("FAIL er_release: got ready=%b wr_en=%b want 0000 0", in_ready, fifo_wr_en);
    end
    @(negedge clk); #1;
    total++;
    if (busy !== 1'b0 || dut.last_owner_q !== 2'd0) begin
      bad++; $display("FAIL er_idle: got busy=%b last_owner=%0d want 0 0", busy, dut.last_owner_q);
    end
    @(negedge clk); #1;
    total++;
    if (grant !== 4'b1000 || log_n !== 1 || log_q[0] !== 4'd5) begin
      bad++; $display("FAIL er_next: got grant=%b n=%0d first=%0d want 1000 1 5", grant, log_n, log_q[0]);
    end
    in_valid = 4'b0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    in_valid = 4'b0010; in_data[7:4] = 4'd6;
    @(negedge clk); #1;
    total++;
    if (grant !== 4'b0010) begin
      bad++; $display("FAIL rmb_grant: got %b want 0010", grant);
    end
    @(negedge clk); reset = 1'b1; in_data[7:4] = 4'd9; #1;
    total++;
    if (fifo_wr_en !== 1'b0 || in_ready !== 4'b0000) begin
      bad++; $display("FAIL rmb_gate: got wr_en=%b ready=%b want 0 0000", fifo_wr_en, in_ready);
    end
    @(negedge clk); reset = 1'b0; in_valid = 4'b0011; #1;
    total++;
    if (grant !== 4'b0000 || busy !== 1'b0 || log_n !== 1 || log_q[0] !== 4'd6) begin
      bad++; $display("FAIL rmb_idle: got grant=%b busy=%b n=%0d want 0000 0 1", grant, busy, log_n);
    end
    @(negedge clk); #1;
    total++;
    if (grant !== 4'b0001) begin
      bad++; $display("FAIL rmb_after: got %b want 0001", grant);
    end
    in_valid = 4'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; in_valid = 4'b0; in_data = 16'h0; rd = 1'b0;
    depth = 5'd16; fifo_load = 1'b1; load_val = 5'd0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
